// File: rtl/ram32k_word_arbiter_if.sv
// rtl/ram32k_word_arbiter_if.sv - requester and RAM signal bundle for the word arbiter
interface ram32k_word_arbiter_if #(
  parameter int ADDR_W = 15
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [1:0]        size0;
  logic [1:0]        size1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [31:0]       wdata0;
  logic [31:0]       wdata1;
  logic              ack0;
  logic              ack1;
  logic [31:0]       rdata;
  logic              busy;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_din;
  logic              ram_we;
  logic [7:0]        ram_dout;

  // Arbiter side: takes requests and RAM read data, drives acks and RAM controls
  modport slave (
    input  req0, req1, we0, we1, size0, size1, addr0, addr1, wdata0, wdata1, ram_dout,
    output ack0, ack1, rdata, busy, ram_addr, ram_din, ram_we
  );

  // Environment side: requesters plus the RAM itself
  modport master (
    output req0, req1, we0, we1, size0, size1, addr0, addr1, wdata0, wdata1, ram_dout,
    input  ack0, ack1, rdata, busy, ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/ram32k_word_arbiter.sv
// rtl/ram32k_word_arbiter.sv - two-port byte/half/word access arbiter for a byte-wide RAM
module ram32k_word_arbiter #(
  parameter int ADDR_W = 15,
  parameter bit RR     = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  ram32k_word_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT  = 2'd1,
    S_DRAIN = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic              r_pref;      // round-robin preferred port
  logic              r_gnt;       // port owning the current transfer
  logic              r_we;
  logic [1:0]        r_beat;
  logic [1:0]        r_last;      // index of final beat (n-1)
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rbuf;
  logic [31:0]       r_rdata;
  logic              r_ack0;
  logic              r_ack1;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [7:0]        r_ram_din;
  logic              r_ram_we;

  logic              w_any;
  logic              w_win;
  logic              w_we;
  logic [1:0]        w_size;
  logic [1:0]        w_last;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic [31:0]       w_rd_final;

  // Winner selection and mux of the winning port's request fields
  always_comb begin
    w_any   = bus.req0 | bus.req1;
    w_win   = (bus.req0 & bus.req1) ? (RR ? r_pref : 1'b0) : bus.req1;
    w_we    = w_win ? bus.we1    : bus.we0;
    w_size  = w_win ? bus.size1  : bus.size0;
    w_addr  = w_win ? bus.addr1  : bus.addr0;
    w_wdata = w_win ? bus.wdata1 : bus.wdata0;
    case (w_size)
      2'd0:    w_last = 2'd0;
      2'd1:    w_last = 2'd1;
      default: w_last = 2'd3;
    endcase
    // Last read byte arrives during DRAIN; merge it with the bytes already collected
    w_rd_final = r_rbuf | ({24'd0, bus.ram_dout} << {r_last, 3'b000});
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_BEAT;
      S_BEAT:  if (r_beat == r_last) w_next = S_DRAIN;
      S_DRAIN: w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Grant latching, RAM beat sequencing, read assembly and ack generation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pref     <= 1'b0;
      r_gnt      <= 1'b0;
      r_we       <= 1'b0;
      r_beat     <= 2'd0;
      r_last     <= 2'd0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_rbuf     <= 32'd0;
      r_rdata    <= 32'd0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_ram_addr <= '0;
      r_ram_din  <= 8'd0;
      r_ram_we   <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt      <= w_win;
            r_we       <= w_we;
            r_last     <= w_last;
            r_addr     <= w_addr;
            r_wdata    <= w_wdata;
            r_beat     <= 2'd0;
            r_rbuf     <= 32'd0;
            r_ram_addr <= w_addr;
            r_ram_din  <= w_wdata[7:0];
            r_ram_we   <= w_we;
            if (RR && bus.req0 && bus.req1) r_pref <= ~w_win;
          end
        end
        S_BEAT: begin
          // RAM output during beat k belongs to the address of beat k-1
          if (r_beat != 2'd0 && !r_we) r_rbuf[{r_beat - 2'd1, 3'b000} +: 8] <= bus.ram_dout;
          if (r_beat == r_last) begin
            r_ram_we <= 1'b0;
          end else begin
            r_beat     <= r_beat + 2'd1;
            r_ram_addr <= r_ram_addr + ADDR_W'(1);
            r_ram_din  <= r_wdata[{r_beat + 2'd1, 3'b000} +: 8];
          end
        end
        S_DRAIN: begin
          r_rdata <= r_we ? 32'd0 : w_rd_final;
          r_ack0  <= ~r_gnt;
          r_ack1  <= r_gnt;
        end
        default: ;
      endcase
    end
  end

  assign bus.ack0     = r_ack0;
  assign bus.ack1     = r_ack1;
  assign bus.rdata    = r_rdata;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.ram_addr = r_ram_addr;
  assign bus.ram_din  = r_ram_din;
  assign bus.ram_we   = r_ram_we;

endmodule

// File: tb/tb_ram32k_word_arbiter.sv
// tb/tb_ram32k_word_arbiter.sv - randomized self-checking bench with a byte-array reference model
module tb_ram32k_word_arbiter;
  localparam int AW = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram32k_word_arbiter_if #(.ADDR_W(AW)) bus ();
  ram32k_word_arbiter_if #(.ADDR_W(AW)) bus_fp ();

  ram32k_word_arbiter #(.ADDR_W(AW), .RR(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  ram32k_word_arbiter #(.ADDR_W(AW), .RR(1'b0)) dut_fp (
    .clk (clk),
    .rst (rst),
    .bus (bus_fp.slave)
  );

  assign bus_fp.ram_dout = 8'd0;

  logic [7:0] ram_mem [0:32767];
  logic [7:0] ref_mem [0:32767];

  // Byte RAM with one-cycle registered read (read-before-write)
  always @(posedge clk) begin
    bus.ram_dout <= ram_mem[bus.ram_addr];
    if (bus.ram_we) ram_mem[bus.ram_addr] = bus.ram_din;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int viol_we = 0;
  int viol_ack = 0;
  logic [AW-1:0] wlog_addr[$];
  logic [7:0]    wlog_din[$];

  // Bus monitor: write beats, write-enable outside transfers, overlapping acks
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ram_we && !bus.busy) viol_we++;
      if (bus.ack0 && bus.ack1) viol_ack++;
      if (bus.ram_we) begin
        wlog_addr.push_back(bus.ram_addr);
        wlog_din.push_back(bus.ram_din);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  // Reference: apply the access to the byte array, return the expected read word
  task automatic model_access(input logic we, input logic [1:0] size, input logic [AW-1:0] addr,
                              input logic [31:0] wdata, output logic [31:0] exp);
    int a;
    exp = 32'd0;
    for (int k = 0; k < nbytes(size); k++) begin
      a = (int'(addr) + k) % 32768;
      if (we) ref_mem[a] = wdata[8*k +: 8];
      else    exp[8*k +: 8] = ref_mem[a];
    end
  endtask

  task automatic drive_port(input int port, input logic req, input logic we, input logic [1:0] size,
                            input logic [AW-1:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      bus.req0 = req; bus.we0 = we; bus.size0 = size; bus.addr0 = addr; bus.wdata0 = wdata;
    end else begin
      bus.req1 = req; bus.we1 = we; bus.size1 = size; bus.addr1 = addr; bus.wdata1 = wdata;
    end
  endtask

  // One isolated transaction; cycle 0 is the cycle the request is first visible
  task automatic do_txn(input int port, input logic we, input logic [1:0] size, input logic [AW-1:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output int lat);
    logic ack;
    @(negedge clk);
    drive_port(port, 1'b1, we, size, addr, wdata);
    lat = -1;
    rd  = 32'hDEAD_BEEF;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (port == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
      end
      ack = (port == 0) ? bus.ack0 : bus.ack1;
      if (ack) begin
        lat = c;
        rd  = bus.rdata;
        break;
      end
    end
  endtask

  task automatic run_and_check(input string tag, input int port, input logic we, input logic [1:0] size,
                               input logic [AW-1:0] addr, input logic [31:0] wdata);
    logic [31:0] rd, exp;
    int lat;
    do_txn(port, we, size, addr, wdata, rd, lat);
    model_access(we, size, addr, wdata, exp);
    check_eq($sformatf("%s_rdata", tag), rd, exp);
    check_eq($sformatf("%s_lat", tag), 32'(lat), 32'(nbytes(size) + 2));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp0, exp1, rd0, rd1;
    logic [AW-1:0] ra;
    int c0, c1, port, nacks, fp0, fp1, acks_after;
    int exp_port;

    for (int i = 0; i < 32768; i++) begin
      ram_mem[i] = 8'($urandom);
      ref_mem[i] = ram_mem[i];
    end
    rst = 1'b1;
    drive_port(0, 1'b0, 1'b0, 2'd0, '0, 32'd0);
    drive_port(1, 1'b0, 1'b0, 2'd0, '0, 32'd0);
    bus_fp.req0 = 1'b0; bus_fp.we0 = 1'b0; bus_fp.size0 = 2'd2; bus_fp.addr0 = '0; bus_fp.wdata0 = 32'd0;
    bus_fp.req1 = 1'b0; bus_fp.we1 = 1'b0; bus_fp.size1 = 2'd2; bus_fp.addr1 = '0; bus_fp.wdata1 = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check_eq("rst_ack0", 32'(bus.ack0), 32'd0);
    check_eq("rst_ack1", 32'(bus.ack1), 32'd0);
    check_eq("rst_rdata", bus.rdata, 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_ram_we", 32'(bus.ram_we), 32'd0);
    check_eq("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    check_eq("rst_ram_din", 32'(bus.ram_din), 32'd0);

    // Word write, checking the individual RAM beats
    wlog_addr.delete(); wlog_din.delete();
    run_and_check("w_word", 0, 1'b1, 2'd2, 15'h0010, 32'hA1B2C3D4);
    check_eq("w_word_nbeats", 32'(wlog_addr.size()), 32'd4);
    for (int k = 0; k < 4 && k < wlog_addr.size(); k++) begin
      check_eq($sformatf("w_word_addr%0d", k), 32'(wlog_addr[k]), 32'h10 + 32'(k));
      check_eq($sformatf("w_word_din%0d", k), 32'(wlog_din[k]), 32'((32'hA1B2C3D4 >> (8*k)) & 32'hFF));
    end

    // Reads of the word just written
    run_and_check("r_word", 0, 1'b0, 2'd2, 15'h0010, 32'd0);
    run_and_check("r_byte", 0, 1'b0, 2'd0, 15'h0012, 32'd0);

    // Halfword wrapping past the top of the address space
    wlog_addr.delete(); wlog_din.delete();
    run_and_check("w_wrap", 1, 1'b1, 2'd1, 15'h7FFF, 32'h00005566);
    check_eq("w_wrap_nbeats", 32'(wlog_addr.size()), 32'd2);
    if (wlog_addr.size() >= 2) begin
      check_eq("w_wrap_addr1", 32'(wlog_addr[1]), 32'd0);
      check_eq("w_wrap_din1", 32'(wlog_din[1]), 32'h55);
    end
    run_and_check("r_wrap", 1, 1'b0, 2'd1, 15'h7FFF, 32'd0);

    // Randomized traffic, isolated transactions on either port
    for (int t = 0; t < 40; t++) begin
      ra = ($urandom_range(0, 3) == 0) ? AW'(15'h7FFC + 15'($urandom_range(0, 3))) : AW'($urandom);
      run_and_check($sformatf("rnd%0d", t), int'($urandom_range(0, 1)), 1'($urandom),
                    2'($urandom_range(0, 3)), ra, $urandom);
    end

    // Asynchronous reset during beat 1 of a word write
    run_and_check("pre_rst", 0, 1'b1, 2'd2, 15'h0200, 32'h11223344);
    @(negedge clk);
    drive_port(0, 1'b1, 1'b1, 2'd2, 15'h0200, 32'hAABBCCDD);
    @(posedge clk);
    #1 bus.req0 = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_ram_we", 32'(bus.ram_we), 32'd0);
    check_eq("arst_busy", 32'(bus.busy), 32'd0);
    check_eq("arst_ack0", 32'(bus.ack0), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    acks_after = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) acks_after++;
    end
    check_eq("arst_no_ack", 32'(acks_after), 32'd0);
    ref_mem[32'h200] = 8'hDD;
    run_and_check("arst_readback", 0, 1'b0, 2'd2, 15'h0200, 32'd0);

    // Port 1 request arriving while port 0 is mid-transfer
    @(negedge clk);
    drive_port(0, 1'b1, 1'b0, 2'd2, 15'h0010, 32'd0);
    model_access(1'b0, 2'd2, 15'h0010, 32'd0, exp0);
    model_access(1'b0, 2'd0, 15'h0123, 32'd0, exp1);
    c0 = -1; c1 = -1; rd0 = 32'd0; rd1 = 32'd0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) begin
        drive_port(0, 1'b0, 1'b1, 2'd2, AW'($urandom), $urandom);
        drive_port(1, 1'b1, 1'b0, 2'd0, 15'h0123, 32'd0);
      end
      if (c == 8) bus.req1 = 1'b0;
      if (bus.ack0 && c0 < 0) begin c0 = c; rd0 = bus.rdata; end
      if (bus.ack1 && c1 < 0) begin c1 = c; rd1 = bus.rdata; end
      if (c1 >= 0) break;
    end
    check_eq("late_ack0_cycle", 32'(c0), 32'd6);
    check_eq("late_rdata0", rd0, exp0);
    check_eq("late_ack1_cycle", 32'(c1), 32'd10);
    check_eq("late_rdata1", rd1, exp1);

    // Both ports held high: round-robin alternates, fixed priority keeps port 0
    @(negedge clk);
    drive_port(0, 1'b1, 1'b0, 2'd2, 15'h0040, 32'd0);
    drive_port(1, 1'b1, 1'b0, 2'd2, 15'h7FFE, 32'd0);
    bus_fp.req0 = 1'b1;
    bus_fp.req1 = 1'b1;
    nacks = 0; fp0 = 0; fp1 = 0; exp_port = 0;
    for (int c = 1; c <= 60 && nacks < 4; c++) begin
      @(negedge clk);
      if (bus_fp.ack0) fp0++;
      if (bus_fp.ack1) fp1++;
      if (bus.ack0 || bus.ack1) begin
        port = bus.ack1 ? 1 : 0;
        check_eq($sformatf("rr_grant%0d", nacks), 32'(port), 32'(exp_port));
        model_access(1'b0, 2'd2, (port == 0) ? 15'h0040 : 15'h7FFE, 32'd0, exp0);
        check_eq($sformatf("rr_rdata%0d", nacks), bus.rdata, exp0);
        exp_port = 1 - exp_port;
        nacks++;
      end
    end
    check_eq("rr_nacks", 32'(nacks), 32'd4);
    check_eq("fp_ack0_count", 32'(fp0), 32'd4);
    check_eq("fp_ack1_count", 32'(fp1), 32'd0);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus_fp.req0 = 1'b0; bus_fp.req1 = 1'b0;
    for (int c = 0; c < 20 && (bus.busy || bus_fp.busy); c++) @(negedge clk);
    check_eq("final_idle", 32'(bus.busy | bus_fp.busy), 32'd0);

    check_eq("we_outside_beat", 32'(viol_we), 32'd0);
    check_eq("ack_overlap", 32'(viol_ack), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
